ex_div: RTL and testbench

- Multi-cycle iterative restoring divider serving DIV/DIVU in the EX stage of the flowCPU_mips pipeline.
- Parametrised successor to the single-cycle EX arithmetic: width is generic, and the unit adds a start/ready handshake, annul and divide-by-zero flagging.
- EX drives start and holds the pipeline stalled (via busy_o) until ready_o. It then writes {remainder, quotient} to HI/LO through the existing hi_o/lo_o/enhilo_o path.

---
 rtl/ex_div_pkg.sv | 22 ++
 rtl/ex_div_if.sv | 24 ++
 rtl/ex_div_step.sv | 19 +
 rtl/ex_div.sv | 151 +++++++++++++++
 tb/tb_ex_div.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_div_pkg.sv
// Shared types and constants for the EX-stage iterative divider.
// The state encoding is 2 bits so HI/LO control logic can decode it cheaply.
package ex_div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_t;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    // EX must stall while the divider is computing or about to report a zero divisor
    function automatic logic is_busy(input div_state_t s);
        return (s == DIV_BYZERO) || (s == DIV_ON);
    endfunction

endpackage

// File: rtl/ex_div_if.sv
// Handshake bundle between the EX stage (master) and the divider (slave).
interface ex_div_if #(
    parameter int WIDTH = 32
);
    logic                   signed_div_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   start_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;
    logic                   busy_o;
    logic                   divzero_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o, divzero_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o, divzero_o
    );
endinterface

// File: rtl/ex_div_step.sv
// One restoring-division iteration: trial-subtract the divisor from the
// upper bits of the partial dividend and shift in the next quotient bit.
module ex_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0]   partial,
    input  logic [WIDTH-1:0]   divisor,
    output logic [2*WIDTH:0]   partial_next
);

    logic [WIDTH:0] diff;

    assign diff = partial[2*WIDTH:WIDTH] - {1'b0, divisor};

    // A borrow out of the top bit means the trial subtraction failed: keep the old remainder
    assign partial_next = diff[WIDTH] ? {partial[2*WIDTH-1:0], 1'b0}
                                      : {diff[WIDTH-1:0], partial[WIDTH-1:0], 1'b1};

endmodule

// File: rtl/ex_div.sv
// Multi-cycle restoring divider for DIV/DIVU: magnitudes are divided
// unsigned over WIDTH iterations, then signs are restored on the final cycle.
module ex_div
    import ex_div_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    ex_div_if.slave     bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    div_state_t             state_reg, state_next;
    logic [CNT_W-1:0]       cnt_reg, cnt_next;
    logic [2*WIDTH:0]       part_reg, part_next;
    logic [WIDTH-1:0]       divisor_reg, divisor_next;
    logic                   sign1_reg, sign1_next;
    logic                   sign2_reg, sign2_next;
    logic                   signed_reg, signed_next;
    logic [2*WIDTH-1:0]     result_reg, result_next;
    logic                   ready_reg, ready_next;
    logic                   divzero_reg, divzero_next;

    logic [WIDTH-1:0]       abs_dividend, abs_divisor;
    logic [2*WIDTH:0]       step_out;
    logic [WIDTH-1:0]       quot_raw, rem_raw, quot_fix, rem_fix;
    logic                   start_ok;

    assign abs_dividend = (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i
                                                                       : bus.opdata1_i;
    assign abs_divisor  = (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i
                                                                       : bus.opdata2_i;
    assign start_ok     = (bus.start_i == DIV_START) && !bus.annul_i;

    ex_div_step #(.WIDTH(WIDTH)) u_step (
        .partial      (part_reg),
        .divisor      (divisor_reg),
        .partial_next (step_out)
    );

    // Quotient sits in the low half, remainder just above it after the final shift
    assign quot_raw = part_reg[WIDTH-1:0];
    assign rem_raw  = part_reg[2*WIDTH:WIDTH+1];
    assign quot_fix = (signed_reg && (sign1_reg ^ sign2_reg)) ? -quot_raw : quot_raw;
    assign rem_fix  = (signed_reg && sign1_reg) ? -rem_raw : rem_raw;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        part_next    = part_reg;
        divisor_next = divisor_reg;
        sign1_next   = sign1_reg;
        sign2_next   = sign2_reg;
        signed_next  = signed_reg;
        result_next  = result_reg;
        ready_next   = ready_reg;
        divzero_next = divzero_reg;

        case (state_reg)
            DIV_FREE: begin
                result_next  = '0;
                ready_next   = DIV_RESULT_NOT_READY;
                divzero_next = 1'b0;
                if (start_ok) begin
                    if (bus.opdata2_i == '0) begin
                        state_next = DIV_BYZERO;
                    end else begin
                        state_next   = DIV_ON;
                        sign1_next   = bus.opdata1_i[WIDTH-1];
                        sign2_next   = bus.opdata2_i[WIDTH-1];
                        signed_next  = bus.signed_div_i;
                        divisor_next = abs_divisor;
                        cnt_next     = '0;
                        part_next    = {{WIDTH{1'b0}}, abs_dividend, 1'b0};
                    end
                end
            end

            DIV_BYZERO: begin
                state_next   = DIV_END;
                result_next  = '0;
                divzero_next = 1'b1;
                ready_next   = DIV_RESULT_READY;
            end

            DIV_ON: begin
                if (bus.annul_i) begin
                    state_next   = DIV_FREE;
                    result_next  = '0;
                    ready_next   = DIV_RESULT_NOT_READY;
                    divzero_next = 1'b0;
                end else if (cnt_reg != CNT_LAST) begin
                    part_next = step_out;
                    cnt_next  = cnt_reg + CNT_W'(1);
                end else begin
                    state_next   = DIV_END;
                    result_next  = {rem_fix, quot_fix};
                    ready_next   = DIV_RESULT_READY;
                    divzero_next = 1'b0;
                end
            end

            DIV_END: begin
                // Result is held for as long as EX keeps start asserted
                if (bus.start_i == DIV_STOP) begin
                    state_next   = DIV_FREE;
                    result_next  = '0;
                    ready_next   = DIV_RESULT_NOT_READY;
                    divzero_next = 1'b0;
                end
            end

            default: state_next = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= DIV_FREE;
            cnt_reg     <= '0;
            part_reg    <= '0;
            divisor_reg <= '0;
            sign1_reg   <= 1'b0;
            sign2_reg   <= 1'b0;
            signed_reg  <= 1'b0;
            result_reg  <= '0;
            ready_reg   <= DIV_RESULT_NOT_READY;
            divzero_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            part_reg    <= part_next;
            divisor_reg <= divisor_next;
            sign1_reg   <= sign1_next;
            sign2_reg   <= sign2_next;
            signed_reg  <= signed_next;
            result_reg  <= result_next;
            ready_reg   <= ready_next;
            divzero_reg <= divzero_next;
        end
    end

    assign bus.result_o  = result_reg;
    assign bus.ready_o   = ready_reg;
    assign bus.divzero_o = divzero_reg;
    assign bus.busy_o    = is_busy(state_reg);

endmodule

// File: tb/tb_ex_div.sv
// Scoreboard bench for ex_div: a 32-bit and an 8-bit instance share clock and reset.
module tb_ex_div;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_div_if #(.WIDTH(32)) bus32 ();
    ex_div_if #(.WIDTH(8))  bus8 ();

    ex_div #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    ex_div #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

    typedef struct {
        logic [63:0] result;
        logic        divzero;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference division in 64-bit arithmetic: {remainder, quotient}, truncating toward zero
    function automatic logic [63:0] model32(input logic sg, input logic [31:0] a, input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sg) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    // Drives one division and waits for ready; cycles counts edges after the start edge (-1 on timeout)
    task automatic run_div32(input logic sg, input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] expect_res, input bit scramble,
                             output int cycles, output int busy_cnt, output logic busy_at_start);
        exp_t e;
        e.result  = expect_res;
        e.divzero = (b == 32'd0);
        sb.push_back(e);
        @(negedge clk);
        bus32.signed_div_i = sg;
        bus32.opdata1_i    = a;
        bus32.opdata2_i    = b;
        bus32.start_i      = 1'b1;
        @(posedge clk);
        #1;
        busy_at_start = bus32.busy_o;
        cycles   = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (bus32.ready_o === 1'b1) begin
                cycles = k;
                break;
            end
            if (bus32.busy_o === 1'b1) busy_cnt++;
            if (scramble && k == 3) begin
                bus32.opdata1_i    = $urandom;
                bus32.opdata2_i    = $urandom;
                bus32.signed_div_i = ~sg;
            end
        end
        $display("div32 %s %h / %h -> result=%h divzero=%b cycles=%0d",
                 sg ? "signed" : "unsigned", a, b, bus32.result_o, bus32.divzero_o, cycles);
    endtask

    task automatic release32();
        @(negedge clk);
        bus32.start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic run_div8(input logic sg, input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] expect_res, output int cycles);
        exp_t e;
        e.result  = {48'd0, expect_res};
        e.divzero = 1'b0;
        sb.push_back(e);
        @(negedge clk);
        bus8.signed_div_i = sg;
        bus8.opdata1_i    = a;
        bus8.opdata2_i    = b;
        bus8.start_i      = 1'b1;
        @(posedge clk);
        cycles = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus8.ready_o === 1'b1) begin
                cycles = k;
                break;
            end
        end
        $display("div8 %s %h / %h -> result=%h cycles=%0d",
                 sg ? "signed" : "unsigned", a, b, bus8.result_o, cycles);
        @(negedge clk);
        bus8.start_i = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({bus32.ready_o, bus32.busy_o, bus32.divzero_o, bus32.result_o} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_hold32: got ready=%b busy=%b dz=%b res=%h, required all 0",
                     bus32.ready_o, bus32.busy_o, bus32.divzero_o, bus32.result_o);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus8.ready_o, bus8.busy_o, bus8.divzero_o, bus8.result_o} !== 19'd0) begin
            n_fail++;
            $display("FAIL reset_idle8: got ready=%b busy=%b dz=%b res=%h, required all 0",
                     bus8.ready_o, bus8.busy_o, bus8.divzero_o, bus8.result_o);
        end
        $display("reset released");
    endtask

    task automatic test_unsigned();
        int cyc, bcnt;
        logic b0;
        exp_t e;
        run_div32(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, cyc, bcnt, b0);
        e = sb.pop_front();
        n_checks++;
        if (bus32.result_o !== e.result) begin
            n_fail++;
            $display("FAIL udiv_100_7 result: got %h required %h", bus32.result_o, e.result);
        end
        n_checks++;
        if (cyc !== 33) begin
            n_fail++;
            $display("FAIL udiv_100_7 latency: got %0d required 33", cyc);
        end
        n_checks++;
        if (bcnt !== 32 || b0 !== 1'b1) begin
            n_fail++;
            $display("FAIL udiv_100_7 busy: got %0d cycles (start %b) required 32 (start 1)", bcnt, b0);
        end
        n_checks++;
        if (bus32.busy_o !== 1'b0 || bus32.divzero_o !== 1'b0) begin
            n_fail++;
            $display("FAIL udiv_100_7 end flags: got busy=%b dz=%b required 0 0", bus32.busy_o, bus32.divzero_o);
        end
        release32();
    endtask

    task automatic test_signed();
        logic [31:0] a_tab [4] = '{32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'h80000000};
        logic [31:0] b_tab [4] = '{32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF};
        logic [63:0] r_tab [4] = '{{32'hFFFFFFFE, 32'hFFFFFFF2}, {32'h00000002, 32'hFFFFFFF2},
                                   {32'hFFFFFFFE, 32'h0000000E}, {32'h00000000, 32'h80000000}};
        int cyc, bcnt;
        logic b0;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            run_div32(1'b1, a_tab[i], b_tab[i], r_tab[i], 1'b0, cyc, bcnt, b0);
            e = sb.pop_front();
            n_checks++;
            if (bus32.result_o !== e.result || cyc !== 33) begin
                n_fail++;
                $display("FAIL sdiv_%0d: got %h in %0d cycles required %h in 33",
                         i, bus32.result_o, cyc, e.result);
            end
            release32();
        end
    endtask

    task automatic test_divzero();
        int cyc, bcnt;
        logic b0;
        exp_t e;
        run_div32(1'b0, 32'h1234, 32'd0, 64'd0, 1'b0, cyc, bcnt, b0);
        e = sb.pop_front();
        n_checks++;
        if (bus32.result_o !== e.result || bus32.divzero_o !== e.divzero) begin
            n_fail++;
            $display("FAIL divzero result: got %h dz=%b required %h dz=%b",
                     bus32.result_o, bus32.divzero_o, e.result, e.divzero);
        end
        n_checks++;
        if (cyc !== 1 || b0 !== 1'b1) begin
            n_fail++;
            $display("FAIL divzero timing: got %0d cycles busy=%b required 1 cycle busy=1", cyc, b0);
        end
        release32();
        run_div32(1'b0, 32'd5, 32'd1, {32'd0, 32'd5}, 1'b0, cyc, bcnt, b0);
        e = sb.pop_front();
        n_checks++;
        if (bus32.divzero_o !== e.divzero || bus32.result_o !== e.result) begin
            n_fail++;
            $display("FAIL divzero_clear: got %h dz=%b required %h dz=%b",
                     bus32.result_o, bus32.divzero_o, e.result, e.divzero);
        end
        release32();
    endtask

    task automatic test_annul();
        int ready_seen = 0;
        int cyc, bcnt;
        logic b0;
        exp_t e;
        @(negedge clk);
        bus32.signed_div_i = 1'b0;
        bus32.opdata1_i    = 32'd100000;
        bus32.opdata2_i    = 32'd3;
        bus32.start_i      = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus32.annul_i = 1'b1;
        bus32.start_i = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus32.busy_o !== 1'b0 || bus32.ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL annul_exit: got busy=%b ready=%b required 0 0", bus32.busy_o, bus32.ready_o);
        end
        @(negedge clk);
        bus32.annul_i = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus32.ready_o !== 1'b0) ready_seen++;
        end
        n_checks++;
        if (ready_seen !== 0) begin
            n_fail++;
            $display("FAIL annul_no_ready: got %0d ready cycles required 0", ready_seen);
        end
        $display("annul at cnt=10 done");
        run_div32(1'b0, 32'hFFFFFFFF, 32'h10, {32'h0000000F, 32'h0FFFFFFF}, 1'b0, cyc, bcnt, b0);
        e = sb.pop_front();
        n_checks++;
        if (bus32.result_o !== e.result) begin
            n_fail++;
            $display("FAIL annul_restart: got %h required %h", bus32.result_o, e.result);
        end
        release32();
    endtask

    task automatic test_hold();
        int cyc, bcnt;
        int unstable = 0;
        logic b0;
        exp_t e;
        run_div32(1'b0, 32'd12345678, 32'd1000, {32'd678, 32'd12345}, 1'b0, cyc, bcnt, b0);
        e = sb.pop_front();
        n_checks++;
        if (bus32.result_o !== e.result) begin
            n_fail++;
            $display("FAIL hold_result: got %h required %h", bus32.result_o, e.result);
        end
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            if (bus32.ready_o !== 1'b1 || bus32.result_o !== e.result) unstable++;
        end
        n_checks++;
        if (unstable !== 0) begin
            n_fail++;
            $display("FAIL hold_stable: got %0d unstable cycles required 0", unstable);
        end
        release32();
        n_checks++;
        if (bus32.ready_o !== 1'b0 || bus32.result_o !== 64'd0) begin
            n_fail++;
            $display("FAIL hold_drop: got ready=%b res=%h required 0 0", bus32.ready_o, bus32.result_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b;
        logic sg;
        int cyc, bcnt;
        logic b0;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            a  = $urandom;
            b  = (i % 2 == 0) ? ($urandom % 256) + 32'd1 : $urandom;
            if (b == 32'd0) b = 32'd3;
            sg = i[0] ^ i[1];
            run_div32(sg, a, b, model32(sg, a, b), 1'b1, cyc, bcnt, b0);
            e = sb.pop_front();
            n_checks++;
            if (bus32.result_o !== e.result || cyc !== 33) begin
                n_fail++;
                $display("FAIL b2b_%0d (%h/%h s=%b): got %h in %0d cycles required %h in 33",
                         i, a, b, sg, bus32.result_o, cyc, e.result);
            end
            release32();
        end
    endtask

    task automatic test_async_reset();
        int cyc, bcnt;
        logic b0;
        exp_t e;
        @(negedge clk);
        bus32.signed_div_i = 1'b0;
        bus32.opdata1_i    = 32'd1000;
        bus32.opdata2_i    = 32'd3;
        bus32.start_i      = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #3;
        n_checks++;
        if (bus32.busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL arst_pre_busy: got %b required 1", bus32.busy_o);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus32.busy_o, bus32.ready_o, bus32.divzero_o, bus32.result_o} !== 67'd0) begin
            n_fail++;
            $display("FAIL arst_mid_on: got busy=%b ready=%b dz=%b res=%h required all 0",
                     bus32.busy_o, bus32.ready_o, bus32.divzero_o, bus32.result_o);
        end
        @(negedge clk);
        bus32.start_i = 1'b0;
        rst = 1'b1;
        run_div32(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, 1'b0, cyc, bcnt, b0);
        e = sb.pop_front();
        n_checks++;
        if (bus32.result_o !== e.result) begin
            n_fail++;
            $display("FAIL arst_redo: got %h required %h", bus32.result_o, e.result);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus32.ready_o !== 1'b0 || bus32.result_o !== 64'd0) begin
            n_fail++;
            $display("FAIL arst_in_end: got ready=%b res=%h required 0 0", bus32.ready_o, bus32.result_o);
        end
        @(negedge clk);
        bus32.start_i = 1'b0;
        rst = 1'b1;
        $display("async reset checks done");
    endtask

    task automatic test_width8();
        logic       s_tab [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] a_tab [3] = '{8'hFF, 8'h80, 8'hF9};
        logic [7:0] b_tab [3] = '{8'h01, 8'hFF, 8'h02};
        logic [15:0] r_tab [3] = '{16'h00FF, 16'h0080, 16'hFFFD};
        int cyc;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            run_div8(s_tab[i], a_tab[i], b_tab[i], r_tab[i], cyc);
            e = sb.pop_front();
            n_checks++;
            if (bus8.result_o !== e.result[15:0] || cyc !== 9) begin
                n_fail++;
                $display("FAIL w8_%0d: got %h in %0d cycles required %h in 9",
                         i, bus8.result_o, cyc, e.result[15:0]);
            end
        end
    endtask

    initial begin
        rst                = 1'b0;
        bus32.signed_div_i = 1'b0;
        bus32.opdata1_i    = '0;
        bus32.opdata2_i    = '0;
        bus32.start_i      = 1'b0;
        bus32.annul_i      = 1'b0;
        bus8.signed_div_i  = 1'b0;
        bus8.opdata1_i     = '0;
        bus8.opdata2_i     = '0;
        bus8.start_i       = 1'b0;
        bus8.annul_i       = 1'b0;
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_annul();
        test_hold();
        test_back_to_back();
        test_async_reset();
        test_width8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
